pcs_block_lock_multi: RTL and testbench
=======================================

Name: pcs_block_lock_multi

Overview:
- Parametrised, multi-lane successor to the single-lane sync-header lock block.
- Implements the 802.3 Figure 49-14 block-lock state machine independently per lane.
- Adds configurable good/invalid thresholds, a slip request/done handshake with the SERDES gearbox, and an aggregate all-lanes-locked status.
- Sits between the per-lane gearbox outputs and the lane deskew / descrambler stage.

Parameters:
- LANE_N, 4, number of independent lanes (1..20).
- SH_CNT_N, 64, sync headers per test window (power of two, 4..1024).
- INVALID_MAX, 16, invalid headers in one window that force loss of lock (1..SH_CNT_N).

Ports:
- clk  in  1  clock.
- nreset  in  1  synchronous active-low reset.
- signal_ok_i  in  LANE_N  per-lane signal_ok from PMA.
- head_v_i  in  LANE_N  per-lane header valid; one 2-bit sync header is presented this cycle.
- head_i  in  2*LANE_N  per-lane sync header; lane k occupies bits [2k+1:2k].
- slip_done_i  in  LANE_N  per-lane gearbox acknowledges that a slip has completed.
- slip_v_o  out  LANE_N  per-lane one-cycle slip request to the gearbox.
- lock_v_o  out  LANE_N  per-lane rx_block_lock.
- all_lock_v_o  out  1  AND of all lock_v_o bits, registered.

Behaviour:
- One clock, synchronous active-low reset (nreset low sampled on rising clk); all state lives in the clk domain.
- Reset values: lock_v_o=0, slip_v_o=0, all_lock_v_o=0, counters=0, every lane FSM in RESET_CNT.
- Per lane: FSM states RESET_CNT, TEST, SLIP_REQ, SLIP_WAIT; lock flag held separately; sh_cnt and invalid_cnt are $clog2(SH_CNT_N)+1 bits wide.
- signal_ok_i low, in any state: next cycle lock=0, slip_v_o=0, counters=0, state RESET_CNT. This overrides every other event, including an outstanding slip.
- RESET_CNT: clears sh_cnt and invalid_cnt, then moves to TEST in the next cycle. Headers arriving during this cycle are ignored.
- TEST: evaluates a header only when head_v_i=1.
  - Valid header (2'b01 or 2'b10): sh_cnt+1.
  - Invalid header (2'b00 or 2'b11): sh_cnt+1 and invalid_cnt+1.
- Decisions in TEST, using the post-increment values from the same cycle, in priority order:
  1. Invalid header with (lock=0 or new invalid_cnt==INVALID_MAX): lock=0, go to SLIP_REQ.
  2. New sh_cnt==SH_CNT_N with invalid_cnt==0: lock=1, counters=0, stay in TEST (64_GOOD).
  3. New sh_cnt==SH_CNT_N with invalid_cnt>0 (lock necessarily 1): counters=0, lock stays 1.
  4. Otherwise: stay in TEST.
- lock_v_o changes on the cycle after the deciding header. Latency from the window's final header to lock_v_o=1 is 1 cycle.
- SLIP_REQ: slip_v_o=1 for exactly one cycle, then SLIP_WAIT.
- SLIP_WAIT: slip_v_o=0; headers are ignored. On slip_done_i=1, go to RESET_CNT. A slip_done_i seen in any other state is ignored.
- A slip_done_i asserted in the same cycle as slip_v_o is not accepted; the earliest accepted slip_done_i is one cycle after slip_v_o.
- Lanes are fully independent; no state is shared between them.
- all_lock_v_o is registered: it follows the AND of lock_v_o with one cycle of delay.
- Window wrap: counters never exceed SH_CNT_N. Reaching SH_CNT_N always clears them in the same update.

Optional Feature:
- Macro PCS_BLOCK_LOCK_STATS_EN.
- Defined: adds output port lock_loss_cnt_o, width 8*LANE_N. Each lane has an 8-bit counter that increments on every 1->0 transition of that lane's lock, whether caused by invalid headers or by signal_ok loss. The counter saturates at 255 and clears only on reset.
- Undefined: the port and the counters do not exist; all other behaviour is identical.

Test Plan:
- Lock acquisition: LANE_N=4, signal_ok=1, 64 consecutive headers of 2'b01 on lane 0 -> lock_v_o[0]=1 exactly 1 cycle after the 64th header. lock_v_o[3:1] stay 0; slip_v_o stays 0.
- Unlocked slip: lane 1 not locked, its 10th header is 2'b11 -> slip_v_o[1] pulses for 1 cycle. Headers are ignored until slip_done_i[1]. After slip_done_i[1] and 64 good headers -> lock_v_o[1]=1.
- Lock hold and loss: lane 2 locked; window with 15 invalid and 49 valid headers -> lock stays 1 and the counters restart. Next window, 16th invalid header -> lock_v_o[2]=0 next cycle and one slip_v_o[2] pulse.
- signal_ok drop: lane 3 in SLIP_WAIT, signal_ok_i[3]=0 for 1 cycle -> FSM returns to RESET_CNT. A late slip_done_i[3] is ignored; lock_v_o[3]=0.
- Aggregate status: all four lanes locked -> all_lock_v_o=1 one cycle after the last lock. nreset=0 for 1 cycle mid-operation -> all outputs 0 the next cycle.
- With PCS_BLOCK_LOCK_STATS_EN defined: 300 lock/unlock cycles on lane 0 -> lock_loss_cnt_o[7:0]=255 (saturated); the counters of the other lanes read 0.

Source files
------------

// File: rtl/pcs_block_lock_multi.sv
//==============================================================================
// Module      : pcs_block_lock_multi
// Description : Per-lane 64b/66b sync-header block lock with gearbox slip
//               handshake and a registered all-lanes-locked status.
//               Optional lock-loss counters: define PCS_BLOCK_LOCK_STATS_EN.
// Revision    : 1.0 - initial multi-lane release
//==============================================================================
`default_nettype none

module pcs_block_lock_multi #(
    parameter int LANE_N      = 4,
    parameter int SH_CNT_N    = 64,
    parameter int INVALID_MAX = 16
) (
    input  logic                  clk,
    input  logic                  nreset,
    input  logic [LANE_N-1:0]     signal_ok_i,
    input  logic [LANE_N-1:0]     head_v_i,
    input  logic [2*LANE_N-1:0]   head_i,
    input  logic [LANE_N-1:0]     slip_done_i,
    output logic [LANE_N-1:0]     slip_v_o,
    output logic [LANE_N-1:0]     lock_v_o,
    output logic                  all_lock_v_o
`ifdef PCS_BLOCK_LOCK_STATS_EN
    ,
    output logic [8*LANE_N-1:0]   lock_loss_cnt_o
`endif
);

    localparam int c_cnt_w = $clog2(SH_CNT_N) + 1;
    localparam logic [c_cnt_w-1:0] c_sh_max  = c_cnt_w'(SH_CNT_N);
    localparam logic [c_cnt_w-1:0] c_inv_max = c_cnt_w'(INVALID_MAX);

    typedef enum logic [1:0] {
        ST_RESET_CNT = 2'd0,
        ST_TEST      = 2'd1,
        ST_SLIP_REQ  = 2'd2,
        ST_SLIP_WAIT = 2'd3
    } state_t;

    logic r_all_lock;

    for (genvar g = 0; g < LANE_N; g++) begin : g_lane
        state_t             r_state;
        state_t             w_state_nxt;
        logic               r_lock;
        logic               w_lock_nxt;
        logic [c_cnt_w-1:0] r_sh_cnt;
        logic [c_cnt_w-1:0] r_inv_cnt;
        logic [c_cnt_w-1:0] w_sh_cnt_nxt;
        logic [c_cnt_w-1:0] w_inv_cnt_nxt;
        logic [c_cnt_w-1:0] w_sh_inc;
        logic [c_cnt_w-1:0] w_inv_inc;
        logic [1:0]         w_head;
        logic               w_head_bad;

        assign w_head     = head_i[2*g +: 2];
        assign w_head_bad = (w_head == 2'b00) || (w_head == 2'b11);
        assign w_sh_inc   = r_sh_cnt + c_cnt_w'(1);
        assign w_inv_inc  = r_inv_cnt + c_cnt_w'(w_head_bad);

        always_comb begin
            w_state_nxt   = r_state;
            w_lock_nxt    = r_lock;
            w_sh_cnt_nxt  = r_sh_cnt;
            w_inv_cnt_nxt = r_inv_cnt;
            // Losing the PMA signal overrides everything, including a pending slip.
            if (!signal_ok_i[g]) begin
                w_state_nxt   = ST_RESET_CNT;
                w_lock_nxt    = 1'b0;
                w_sh_cnt_nxt  = '0;
                w_inv_cnt_nxt = '0;
            end else begin
                case (r_state)
                    ST_RESET_CNT: begin
                        w_sh_cnt_nxt  = '0;
                        w_inv_cnt_nxt = '0;
                        w_state_nxt   = ST_TEST;
                    end
                    ST_TEST: begin
                        if (head_v_i[g]) begin
                            if (w_head_bad && (!r_lock || (w_inv_inc == c_inv_max))) begin
                                w_lock_nxt    = 1'b0;
                                w_state_nxt   = ST_SLIP_REQ;
                                w_sh_cnt_nxt  = '0;
                                w_inv_cnt_nxt = '0;
                            end else if (w_sh_inc == c_sh_max) begin
                                // Window complete; a clean window grants lock.
                                if (w_inv_inc == '0) begin
                                    w_lock_nxt = 1'b1;
                                end
                                w_sh_cnt_nxt  = '0;
                                w_inv_cnt_nxt = '0;
                            end else begin
                                w_sh_cnt_nxt  = w_sh_inc;
                                w_inv_cnt_nxt = w_inv_inc;
                            end
                        end
                    end
                    ST_SLIP_REQ: begin
                        w_state_nxt = ST_SLIP_WAIT;
                    end
                    ST_SLIP_WAIT: begin
                        if (slip_done_i[g]) begin
                            w_state_nxt = ST_RESET_CNT;
                        end
                    end
                    default: begin
                        w_state_nxt = ST_RESET_CNT;
                    end
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (!nreset) begin
                r_state   <= ST_RESET_CNT;
                r_lock    <= 1'b0;
                r_sh_cnt  <= '0;
                r_inv_cnt <= '0;
            end else begin
                r_state   <= w_state_nxt;
                r_lock    <= w_lock_nxt;
                r_sh_cnt  <= w_sh_cnt_nxt;
                r_inv_cnt <= w_inv_cnt_nxt;
            end
        end

        // The request is a pure state decode, so it lasts exactly one cycle.
        assign slip_v_o[g] = (r_state == ST_SLIP_REQ);
        assign lock_v_o[g] = r_lock;

`ifdef PCS_BLOCK_LOCK_STATS_EN
        logic [7:0] r_loss_cnt;

        always_ff @(posedge clk) begin
            if (!nreset) begin
                r_loss_cnt <= '0;
            end else if (r_lock && !w_lock_nxt && (r_loss_cnt != 8'hFF)) begin
                r_loss_cnt <= r_loss_cnt + 8'd1;
            end
        end

        assign lock_loss_cnt_o[8*g +: 8] = r_loss_cnt;
`endif
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_all_lock <= 1'b0;
        end else begin
            r_all_lock <= &lock_v_o;
        end
    end

    assign all_lock_v_o = r_all_lock;

endmodule

`default_nettype wire

// File: tb/tb_pcs_block_lock_multi.sv
//==============================================================================
// Module      : tb_pcs_block_lock_multi
// Description : Scoreboard bench for pcs_block_lock_multi (LANE_N=4, SH_CNT_N=64).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_pcs_block_lock_multi;

    localparam int LANE_N = 4;

    typedef struct packed {
        logic [LANE_N-1:0] lock;
        logic [LANE_N-1:0] slip;
        logic              all;
    } exp_t;

    logic                clk = 1'b0;
    logic                nreset;
    logic [LANE_N-1:0]   signal_ok_i;
    logic [LANE_N-1:0]   head_v_i;
    logic [2*LANE_N-1:0] head_i;
    logic [LANE_N-1:0]   slip_done_i;
    logic [LANE_N-1:0]   slip_v_o;
    logic [LANE_N-1:0]   lock_v_o;
    logic                all_lock_v_o;
`ifdef PCS_BLOCK_LOCK_STATS_EN
    logic [8*LANE_N-1:0] lock_loss_cnt_o;
`endif

    int n_checks = 0;
    int n_errors = 0;

    exp_t  exp_q[$];
    string tag_q[$];

    logic [LANE_N-1:0] exp_lock = '0;
    logic [LANE_N-1:0] exp_slip = '0;
    logic [LANE_N-1:0] cur_lock = '0;
    string             cur_tag  = "init";

    always #5 clk = ~clk;

    pcs_block_lock_multi #(
        .LANE_N      (LANE_N),
        .SH_CNT_N    (64),
        .INVALID_MAX (16)
    ) dut (
        .clk             (clk),
        .nreset          (nreset),
        .signal_ok_i     (signal_ok_i),
        .head_v_i        (head_v_i),
        .head_i          (head_i),
        .slip_done_i     (slip_done_i),
        .slip_v_o        (slip_v_o),
        .lock_v_o        (lock_v_o),
        .all_lock_v_o    (all_lock_v_o)
`ifdef PCS_BLOCK_LOCK_STATS_EN
        ,
        .lock_loss_cnt_o (lock_loss_cnt_o)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Push what the outputs must show after the coming edge, then compare.
    task automatic step();
        exp_t  e;
        string t;
        e.lock = exp_lock;
        e.slip = exp_slip;
        e.all  = nreset ? &cur_lock : 1'b0;
        exp_q.push_back(e);
        tag_q.push_back(cur_tag);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check_eq({t, "/lock"}, 32'(lock_v_o), 32'(e.lock));
        check_eq({t, "/slip"}, 32'(slip_v_o), 32'(e.slip));
        check_eq({t, "/all"},  32'(all_lock_v_o), 32'(e.all));
        cur_lock    = exp_lock;
        exp_slip    = '0;
        head_v_i    = '0;
        slip_done_i = '0;
    endtask

    task automatic send(input int lane, input logic [1:0] hdr);
        head_v_i[lane]       = 1'b1;
        head_i[2*lane +: 2]  = hdr;
        step();
    endtask

    // 64 valid headers; lock must rise exactly after the last one.
    task automatic acquire(input int lane, input string tag);
        cur_tag = tag;
        for (int i = 0; i < 64; i++) begin
            if (i == 63) exp_lock[lane] = 1'b1;
            send(lane, (i % 2 == 0) ? 2'b01 : 2'b10);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        nreset      = 1'b0;
        signal_ok_i = '1;
        head_v_i    = '0;
        head_i      = '0;
        slip_done_i = '0;
        #1;
        cur_tag = "reset";
        step();
        step();
        nreset  = 1'b1;
        cur_tag = "idle";
        step();

        // Lane 0 acquisition
        acquire(0, "acq0");

        // Lane 1: invalid header while unlocked
        cur_tag = "slip1";
        for (int i = 0; i < 9; i++) send(1, 2'b01);
        exp_slip[1] = 1'b1;
        send(1, 2'b11);
        cur_tag = "done_same_cycle";
        slip_done_i[1] = 1'b1;
        step();
        cur_tag = "slipwait1";
        for (int i = 0; i < 70; i++) send(1, 2'b01);
        cur_tag = "done1";
        slip_done_i[1] = 1'b1;
        step();
        cur_tag = "rstcnt_ignore1";
        send(1, 2'b00);
        acquire(1, "acq1");

        // Lane 2: hold lock through 15 invalids, lose it on the 16th
        acquire(2, "acq2");
        cur_tag = "hold2";
        for (int i = 0; i < 64; i++) send(2, (i < 14 || i == 63) ? 2'b00 : 2'b01);
        cur_tag = "win2";
        for (int i = 0; i < 15; i++) send(2, (i % 2 == 0) ? 2'b11 : 2'b00);
        cur_tag = "loss2";
        exp_lock[2] = 1'b0;
        exp_slip[2] = 1'b1;
        send(2, 2'b11);
        cur_tag = "after_loss2";
        send(2, 2'b01);

        // Lane 3: signal_ok drop while waiting for slip completion
        cur_tag = "slip3";
        exp_slip[3] = 1'b1;
        send(3, 2'b00);
        cur_tag = "wait3";
        step();
        cur_tag = "sigok3";
        signal_ok_i[3] = 1'b0;
        step();
        signal_ok_i[3] = 1'b1;
        cur_tag = "late_done3";
        slip_done_i[3] = 1'b1;
        step();
        acquire(3, "acq3");

        // Aggregate status
        cur_tag = "done2";
        slip_done_i[2] = 1'b1;
        step();
        cur_tag = "rstcnt2";
        step();
        acquire(2, "reacq2");
        cur_tag = "all_lock";
        step();
        step();
        cur_tag = "rst_mid";
        nreset   = 1'b0;
        exp_lock = '0;
        step();
        nreset  = 1'b1;
        cur_tag = "post_rst";
        step();

        // signal_ok drop on a locked lane
        acquire(0, "reacq0");
        cur_tag = "sigok0";
        signal_ok_i[0] = 1'b0;
        exp_lock[0]    = 1'b0;
        step();
        signal_ok_i[0] = 1'b1;
        step();

`ifdef PCS_BLOCK_LOCK_STATS_EN
        cur_tag = "stats_rst";
        nreset  = 1'b0;
        step();
        nreset  = 1'b1;
        step();
        for (int it = 0; it < 300; it++) begin
            acquire(0, "stats_acq");
            cur_tag = "stats_drop";
            signal_ok_i[0] = 1'b0;
            exp_lock[0]    = 1'b0;
            step();
            signal_ok_i[0] = 1'b1;
            check_eq("loss_cnt0", 32'(lock_loss_cnt_o[7:0]), (it < 255) ? 32'(it + 1) : 32'd255);
            step();
        end
        check_eq("loss_cnt1", 32'(lock_loss_cnt_o[15:8]), 32'd0);
        check_eq("loss_cnt2", 32'(lock_loss_cnt_o[23:16]), 32'd0);
        check_eq("loss_cnt3", 32'(lock_loss_cnt_o[31:24]), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
